// File: rtl/toggle_watch.sv
// toggle_watch: synchronises a T flip-flop's Q output and counts its toggles over a
// programmable window, flagging a stall when Q stays quiet for STALL_LIM window cycles.
module toggle_watch #(
    parameter int CNT_W     = 8,
    parameter int WIN_W     = 16,
    parameter int STALL_LIM = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             stall,
    output logic             q_level
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [WIN_W-1:0] IDLE_MAX    = '1;
    localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
    localparam logic [WIN_W-1:0] WIN_ZERO    = '0;
    localparam logic [WIN_W-1:0] STALL_LIM_W = WIN_W'(STALL_LIM);

    state_t             state_q,     state_d;
    logic [WIN_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIN_W-1:0]   idle_q,      idle_d;
    logic               stall_q,     stall_d;
    logic               s1_q,        s1_d;
    logic               s2_q,        s2_d;
    logic               s3_q,        s3_d;
    logic               toggle_seen;

    // s1/s2 resolve metastability; s3 is only the delayed copy for edge detection
    always_comb begin
        s1_d        = q_in;
        s2_d        = s1_q;
        s3_d        = s2_q;
        toggle_seen = s2_q ^ s3_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            stall_q     <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            stall_q     <= stall_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        stall_d     = stall_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = window_len;
                    cnt_d       = '0;
                    idle_d      = '0;
                    stall_d     = 1'b0;
                    state_d     = (window_len != WIN_ZERO) ? COUNT : DONE;
                end
            end
            COUNT: begin
                remaining_d = remaining_q - WIN_ONE;
                if (toggle_seen) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    idle_d = '0;
                end else begin
                    if (idle_q != IDLE_MAX) begin
                        idle_d = idle_q + WIN_ONE;
                    end
                    if (idle_d >= STALL_LIM_W) begin
                        stall_d = 1'b1;
                    end
                end
                // the edge that consumes the last remaining cycle is still counted above
                if (remaining_q == WIN_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == COUNT);
        done       = (state_q == DONE);
        toggle_cnt = cnt_q;
        stall      = stall_q;
        q_level    = s2_q;
    end

endmodule

// File: tb/tb_toggle_watch.sv
// tb_toggle_watch: table-driven windows, hand-written reset sequence and random stimulus,
// all checked each cycle against a cycle-indexed window model of toggle_watch.
module tb_toggle_watch;

    localparam int CNT_W     = 8;
    localparam int WIN_W     = 16;
    localparam int STALL_LIM = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             q_in;
    logic             start;
    logic [WIN_W-1:0] window_len;

    logic             busy, done, stall, q_level;
    logic [CNT_W-1:0] toggle_cnt;
    logic             busy4, done4, stall4, q_level4;
    logic [3:0]       toggle_cnt4;

    int checks = 0;
    int passed = 0;

    // model state: t_now is the index of the most recent rising edge
    int t_now;
    int qh[3];
    bit m_active;
    int m_s, m_end, m_free;
    int m_cnt, m_cnt4, m_idle;
    bit m_stall;

    typedef struct {
        int len;
        int first;
        int period;
        int ntog;
        int restart;
        int exp_cnt;
        int exp_cnt4;
        int exp_stall;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    toggle_watch #(.CNT_W(CNT_W), .WIN_W(WIN_W), .STALL_LIM(STALL_LIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .start      (start),
        .window_len (window_len),
        .busy       (busy),
        .done       (done),
        .toggle_cnt (toggle_cnt),
        .stall      (stall),
        .q_level    (q_level)
    );

    toggle_watch #(.CNT_W(4), .WIN_W(WIN_W), .STALL_LIM(STALL_LIM)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .q_in       (q_in),
        .start      (start),
        .window_len (window_len),
        .busy       (busy4),
        .done       (done4),
        .toggle_cnt (toggle_cnt4),
        .stall      (stall4),
        .q_level    (q_level4)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) qh[i] = 0;
        m_active = 1'b0;
        m_free   = 0;
        m_cnt    = 0;
        m_cnt4   = 0;
        m_idle   = 0;
        m_stall  = 1'b0;
    endtask

    // a q_in change sampled at edge t is counted at edge t+2 if that edge lies in the window
    task automatic model_edge();
        int tog;
        t_now++;
        if (reset) begin
            model_clear();
            return;
        end
        tog = qh[1] ^ qh[2];
        if (m_active && t_now > m_s && t_now <= m_end) begin
            if (tog != 0) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle >= STALL_LIM) m_stall = 1'b1;
            end
        end
        if (start && t_now >= m_free) begin
            m_active = 1'b1;
            m_s      = t_now;
            m_end    = t_now + int'(window_len);
            m_free   = m_end + 2;
            m_cnt    = 0;
            m_cnt4   = 0;
            m_idle   = 0;
            m_stall  = 1'b0;
        end
        qh[2] = qh[1];
        qh[1] = qh[0];
        qh[0] = int'(q_in);
    endtask

    task automatic check_all();
        int exp_busy;
        int exp_done;
        exp_busy = (m_active && t_now >= m_s && t_now < m_end) ? 1 : 0;
        exp_done = (m_active && t_now == m_end) ? 1 : 0;
        check_output("busy",      int'(busy),        exp_busy);
        check_output("done",      int'(done),        exp_done);
        check_output("toggle_cnt", int'(toggle_cnt), m_cnt);
        check_output("stall",     int'(stall),       int'(m_stall));
        check_output("q_level",   int'(q_level),     qh[1]);
        check_output("busy4",     int'(busy4),       exp_busy);
        check_output("done4",     int'(done4),       exp_done);
        check_output("toggle_cnt4", int'(toggle_cnt4), m_cnt4);
        check_output("stall4",    int'(stall4),      int'(m_stall));
        check_output("q_level4",  int'(q_level4),    qh[1]);
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        apply_stimulus();
        reset = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int done_seen;
        int done_k;
        int rel;
        bit flip;
        done_seen = 0;
        done_k    = -1;
        for (int k = -2; k <= v.len + 3; k++) begin
            rel  = k - v.first;
            flip = 1'b0;
            if (v.ntog > 0 && rel >= 0) begin
                if (v.period == 0) flip = (rel == 0);
                else flip = (rel % v.period == 0) && (rel / v.period < v.ntog);
            end
            if (flip) q_in = ~q_in;
            start      = (k == 0 || k == v.restart);
            window_len = WIN_W'(v.len);
            apply_stimulus();
            if (done) begin
                done_seen++;
                done_k = k;
            end
        end
        start = 1'b0;
        check_output($sformatf("vec%0d_done_count", idx), done_seen, 1);
        check_output($sformatf("vec%0d_done_edge", idx), done_k, v.len);
        check_output($sformatf("vec%0d_cnt", idx), int'(toggle_cnt), v.exp_cnt);
        check_output($sformatf("vec%0d_cnt4", idx), int'(toggle_cnt4), v.exp_cnt4);
        check_output($sformatf("vec%0d_stall", idx), int'(stall), v.exp_stall);
    endtask

    initial begin
        int done_seen;

        vecs[0] = '{40, 5, 4, 8, -100, 8, 8, 0};
        vecs[1] = '{0, -100, 0, 0, -100, 0, 0, 0};
        vecs[2] = '{1, -1, 0, 1, -100, 1, 1, 0};
        vecs[3] = '{200, -100, 0, 0, -100, 0, 0, 1};
        vecs[4] = '{100, 1, 2, 50, -100, 49, 15, 0};
        vecs[5] = '{40, 5, 4, 8, 10, 8, 8, 0};

        reset      = 1'b1;
        q_in       = 1'b0;
        start      = 1'b0;
        window_len = '0;
        t_now      = 0;
        m_s        = 0;
        m_end      = 0;
        model_clear();
        #1;
        check_all();
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus();

        for (int i = 0; i < 6; i++) begin
            run_vector(vecs[i], i);
        end

        // reset mid-window: the window is abandoned, then q_in=1 alone must not count
        start      = 1'b1;
        window_len = WIN_W'(100);
        apply_stimulus();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) q_in = ~q_in;
            apply_stimulus();
        end
        q_in = 1'b0;
        pulse_reset();
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_cnt", int'(toggle_cnt), 0);
        check_output("reset_stall", int'(stall), 0);
        q_in      = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus();
            if (done) done_seen++;
        end
        check_output("reset_no_done", done_seen, 0);
        check_output("reset_cnt_after", int'(toggle_cnt), 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) q_in = ~q_in;
            start      = ($urandom_range(0, 15) == 0);
            window_len = WIN_W'($urandom_range(0, 90));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else apply_stimulus();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/toggle_watch.md
# toggle_watch

Downstream monitor for the T flip-flop stage. Synchronises the flip-flop's Q output into its own clock domain and detects each toggle. Over a programmable measurement window it counts toggles and flags a stall when Q stops toggling for too long. Results are used for self-check of toggle/divider chains and for bench-free on-chip sanity checks.

## Interface
- CNT_W, 8: width of toggle counter
- WIN_W, 16: width of window length and stall counters
- STALL_LIM, 64: idle-cycle limit (no toggle seen) that sets stall; must be ≥1 and < 2^WIN_W

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears all state
- q_in  input  1  Q from the T flip-flop; treated as asynchronous
- start  input  1  single-cycle request to begin a measurement window
- window_len  input  WIN_W  window length in clk cycles, sampled on start
- busy  output  1  high while a window is in progress
- done  output  1  one-cycle pulse when a window completes
- toggle_cnt  output  CNT_W  toggles counted in the current or last window
- stall  output  1  sticky: STALL_LIM consecutive window cycles without a toggle
- q_level  output  1  synchronised level of q_in

## Operation
- Sync chain: s1 ← q_in, s2 ← s1, s3 ← s2, all updated every cycle in every state. q_level = s2. edge = s2 XOR s3, combinational.
- States:
  - IDLE: start=1 → latch remaining = window_len, clear toggle_cnt, idle_cnt and stall. Go to COUNT if window_len ≠ 0, otherwise go to DONE.
  - COUNT, per cycle:
    - Decrement remaining.
    - If edge=1: toggle_cnt += 1 (saturates at 2^CNT_W−1) and idle_cnt ← 0.
    - Else: idle_cnt += 1 (saturates). When idle_cnt reaches STALL_LIM, set stall.
    - The edge at which remaining==1 is the last counted edge; go to DONE.
  - DONE: one cycle, then IDLE.
- busy = (state==COUNT). done = (state==DONE).
- toggle_cnt and stall hold their values in IDLE and DONE until the next accepted start.
- start during COUNT or DONE is ignored, with no restart.
- An edge coinciding with the start-accept edge is not counted.
- Reset at any time: state IDLE, remaining 0. Counters and s1/s2/s3 go to 0. An in-progress window is abandoned and gives no done pulse.
- Because s1..s3 reset to 0, q_in=1 at reset release produces one edge 2 cycles later. It is counted only if a window is already running.

## Timing
- Reset values: busy=0, done=0, toggle_cnt=0, stall=0, q_level=0.
- Let q_in change with setup before rising edge E0. Then:
  - s2 updates at E1, and edge is high between E1 and E2.
  - toggle_cnt increments at E2.
  - Toggle-to-count latency: 2 cycles.
- start high at edge S:
  - busy high from S through S+window_len (exclusive).
  - Window edges are S+1 … S+window_len.
  - done high for the single cycle after edge S+window_len.
  - busy falls at the same edge where done rises.
- window_len=0: done pulses in the cycle after S; busy never rises.
- Stall: with no edges, stall sets at edge S+STALL_LIM, provided window_len ≥ STALL_LIM.
- Two q_in toggles closer than 1 cycle may merge; q_in must hold each level ≥2 clk cycles for an exact count.

## Test plan
- Reset check: assert reset mid-window (window_len=100, 10 cycles in) → busy=0, done never pulses, toggle_cnt=0, stall=0. After release, q_in=1 and no start → toggle_cnt stays 0.
- Basic count: window_len=40; q_in toggles at start+5, +9, …, +33 (8 toggles) → done one cycle after edge S+40, toggle_cnt=8, stall=0.
- Zero and unit window:
  - window_len=0 → done in the cycle after S, busy never 1, toggle_cnt=0.
  - window_len=1 with an edge high at S+1 → toggle_cnt=1.
- Stall: STALL_LIM=64, window_len=200, q_in constant → stall rises at edge S+64 and stays set through done. The next start clears it.
- Saturation: CNT_W=4; q_in toggles every 2 cycles; window_len=100 → toggle_cnt=15 at done.
- Start ignored while busy: second start 10 cycles into a 40-cycle window → done occurs only once, at S+40 timing, and the count is unaffected.
